// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] PC_INC           = 32'd4;

    // True when an address cannot be fetched as a 32-bit word.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// Fetch PC, pending redirect target and kill flag for the in-flight request.
module ifu_pc_reg
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pc_load_i,
    input  logic [31:0] pc_next_i,
    input  logic        kill_set_i,
    input  logic        kill_clr_i,
    input  logic [31:0] tgt_i,
    output logic [31:0] pc_o,
    output logic [31:0] tgt_o,
    output logic        kill_o
);

    logic [31:0] pc_q;
    logic [31:0] tgt_q;
    logic        kill_q;

    // PC update, and latch of the most recent redirect while a request is in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q   <= RESET_PC;
            tgt_q  <= '0;
            kill_q <= 1'b0;
        end else begin
            if (pc_load_i) begin
                pc_q <= pc_next_i;
            end
            if (kill_set_i) begin
                kill_q <= 1'b1;
                tgt_q  <= tgt_i;
            end else if (kill_clr_i) begin
                kill_q <= 1'b0;
            end
        end
    end

    assign pc_o   = pc_q;
    assign tgt_o  = tgt_q;
    assign kill_o = kill_q;

endmodule

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch: request, wait for response, offer to decode.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic         inst_err_q, inst_err_d;

    logic [31:0]  pc_q, tgt_q;
    logic         kill_q;
    logic         pc_load, kill_set, kill_clr;
    logic [31:0]  pc_next;
    logic         jump;
    logic [31:0]  jump_pc;

    ifu_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .pc_load_i  (pc_load),
        .pc_next_i  (pc_next),
        .kill_set_i (kill_set),
        .kill_clr_i (kill_clr),
        .tgt_i      (redirect_pc),
        .pc_o       (pc_q),
        .tgt_o      (tgt_q),
        .kill_o     (kill_q)
    );

    // State and output-buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            inst_q     <= '0;
            inst_pc_q  <= '0;
            inst_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            inst_err_q <= inst_err_d;
        end
    end

    // Next-state logic. Redirects that take effect now (IDLE/OUT, or a dropped
    // response in WAIT) share one jump path; a misaligned target skips memory
    // and presents a faulting nop, keeping the PC word-aligned.
    always_comb begin
        state_d    = state_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        inst_err_d = inst_err_q;
        pc_load    = 1'b0;
        pc_next    = pc_q;
        kill_set   = 1'b0;
        kill_clr   = 1'b0;
        jump       = 1'b0;
        jump_pc    = redirect_pc;

        case (state_q)
            ST_IDLE: begin
                if (redirect_valid) begin
                    jump = 1'b1;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                kill_set = redirect_valid;
                if (imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    if (kill_q || redirect_valid) begin
                        jump     = 1'b1;
                        jump_pc  = redirect_valid ? redirect_pc : tgt_q;
                        kill_clr = 1'b1;
                    end else begin
                        inst_d     = imem_rsp_data;
                        inst_pc_d  = pc_q;
                        inst_err_d = imem_rsp_err;
                        state_d    = ST_OUT;
                    end
                end else begin
                    kill_set = redirect_valid;
                end
            end
            ST_OUT: begin
                if (redirect_valid) begin
                    jump = 1'b1;
                end else if (inst_ready) begin
                    pc_load = 1'b1;
                    pc_next = pc_q + PC_INC;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (jump) begin
            pc_load = 1'b1;
            if (is_misaligned(jump_pc)) begin
                pc_next    = {jump_pc[31:2], 2'b00};
                inst_d     = NOP_INST;
                inst_pc_d  = jump_pc;
                inst_err_d = 1'b1;
                state_d    = ST_OUT;
            end else begin
                pc_next = jump_pc;
                state_d = ST_REQ;
            end
        end
    end

    assign imem_req_valid = (state_q == ST_REQ);
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == ST_OUT);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign inst_err       = inst_err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus random traffic
// checked against a stream-level model of the fetch PC.
module tb_ifu_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    ifu_fetch #(
        .RESET_PC (32'h8000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Stream-level model: the PC of the next instruction decode should see,
    // or a pending misaligned-redirect fault, plus the one stale request.
    logic [31:0] exp_pc;
    bit          exp_fault;
    logic [31:0] fault_pc;
    bit          stale;
    logic [31:0] stale_addr;
    int          n_hs;

    // Memory responder state.
    bit          outstanding;
    logic [31:0] out_addr;
    int          wait_cnt;
    int          lat;
    bit          inject;
    bit          req_hold;

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0093;
        return (a * 32'h9E37_79B9) ^ 32'h1234_0000;
    endfunction

    function automatic logic memerr(input logic [31:0] a);
        return a[6:2] == 5'h1F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc      = 32'h8000_0000;
        exp_fault   = 1'b0;
        fault_pc    = '0;
        stale       = 1'b0;
        stale_addr  = '0;
        outstanding = 1'b0;
        out_addr    = '0;
        wait_cnt    = 0;
        req_hold    = 1'b0;
    endtask

    // One clock: drive inputs at the falling edge, check registered outputs
    // against the model, advance the model, then let the rising edge happen.
    task automatic cyc(input bit rdy, input bit irdy, input bit redir, input logic [31:0] rpc);
        logic [31:0] ea;
        bit          inflight;
        bit          deliver;
        @(negedge clk);
        imem_req_ready = rdy;
        inst_ready     = irdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        deliver        = outstanding && (wait_cnt == 0);
        if (deliver) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memword(out_addr);
            imem_rsp_err   = memerr(out_addr);
        end else if (inject) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
            imem_rsp_err   = 1'b1;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            imem_rsp_err   = 1'b0;
        end

        if (req_hold) chk("req_valid_hold", 32'(imem_req_valid), 32'd1);
        if (imem_req_valid) begin
            ea = stale ? stale_addr : (exp_fault ? 32'hFFFF_FFFF : exp_pc);
            chk("req_addr", imem_req_addr, ea);
        end

        if (inst_valid) begin
            if (exp_fault) begin
                chk("inst_fault", inst, NOP);
                chk("inst_pc_fault", inst_pc, fault_pc);
                chk("inst_err_fault", 32'(inst_err), 32'd1);
            end else begin
                chk("inst", inst, memword(exp_pc));
                chk("inst_pc", inst_pc, exp_pc);
                chk("inst_err", 32'(inst_err), 32'(memerr(exp_pc)));
            end
            if (irdy) begin
                n_hs++;
                if (exp_fault) begin
                    exp_pc    = {fault_pc[31:2], 2'b00} + 32'd4;
                    exp_fault = 1'b0;
                end else begin
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end

        inflight = imem_req_valid || outstanding;
        if (redir) begin
            if (inflight && !stale) begin
                stale      = 1'b1;
                stale_addr = exp_pc;
            end
            if (rpc[1:0] != 2'b00) begin
                exp_fault = 1'b1;
                fault_pc  = rpc;
            end else begin
                exp_fault = 1'b0;
                exp_pc    = rpc;
            end
        end

        if (imem_req_valid && rdy) begin
            outstanding = 1'b1;
            out_addr    = imem_req_addr;
            wait_cnt    = lat - 1;
        end else if (deliver) begin
            outstanding = 1'b0;
            stale       = 1'b0;
        end else if (outstanding) begin
            wait_cnt--;
        end
        req_hold = imem_req_valid && !rdy;
        @(posedge clk);
    endtask

    // One-cycle reset pulse; returns just after the first rising edge following release.
    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        model_reset();
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_inst_err", 32'(inst_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        if (inject) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
            imem_rsp_err   = 1'b1;
        end
        #1;
        chk("idle_req_valid", 32'(imem_req_valid), 32'd0);
        @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  h0;
        bit  found;
        logic [31:0] rpc;

        rst_n  = 1'b0;
        inject = 1'b0;
        lat    = 1;
        n_hs   = 0;

        // First fetch after reset, 1-cycle memory, full throughput.
        do_reset();
        #1;
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h8000_0000);
        cyc(1, 1, 0, '0);
        cyc(1, 1, 0, '0);
        #1;
        chk("first_inst_valid", 32'(inst_valid), 32'd1);
        chk("first_inst", inst, 32'h0010_0093);
        chk("first_inst_pc", inst_pc, 32'h8000_0000);
        chk("first_inst_err", 32'(inst_err), 32'd0);
        cyc(1, 1, 0, '0);
        #1;
        chk("second_req_addr", imem_req_addr, 32'h8000_0004);
        h0 = n_hs;
        repeat (9) cyc(1, 1, 0, '0);
        chk("throughput_3cyc", 32'(n_hs - h0), 32'd3);

        // Decode stalls for 5 cycles while an instruction is offered.
        cyc(1, 0, 0, '0);
        cyc(1, 0, 0, '0);
        repeat (5) cyc(1, 0, 0, '0);
        #1;
        chk("stall_inst_valid", 32'(inst_valid), 32'd1);
        chk("stall_inst_pc", inst_pc, 32'h8000_0010);
        chk("stall_inst", inst, memword(32'h8000_0010));
        chk("stall_no_req", 32'(imem_req_valid), 32'd0);

        // Redirect while waiting for a slow response.
        cyc(1, 1, 0, '0);
        lat = 3;
        cyc(1, 0, 0, '0);
        cyc(1, 0, 1, 32'h8000_0100);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            cyc(0, 0, 0, '0);
            #1;
            if (imem_req_valid) found = 1'b1;
        end
        chk("wait_redir_req_seen", 32'(found), 32'd1);
        chk("wait_redir_addr", imem_req_addr, 32'h8000_0100);
        chk("wait_redir_no_inst", 32'(inst_valid), 32'd0);

        // Memory stalls 4 cycles, redirect arrives in the 2nd.
        lat = 1;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 0, i == 2, 32'h8000_0104);
            #1;
            chk("req_stall_valid", 32'(imem_req_valid), 32'd1);
            chk("req_stall_addr", imem_req_addr, 32'h8000_0000);
        end
        cyc(1, 0, 0, '0);
        cyc(1, 0, 0, '0);
        #1;
        chk("req_redir_valid", 32'(imem_req_valid), 32'd1);
        chk("req_redir_addr", imem_req_addr, 32'h8000_0104);
        chk("req_redir_no_inst", 32'(inst_valid), 32'd0);

        // Misaligned redirect while an instruction is offered.
        cyc(1, 0, 0, '0);
        cyc(1, 0, 0, '0);
        cyc(1, 0, 1, 32'h8000_0102);
        #1;
        chk("mis_inst_valid", 32'(inst_valid), 32'd1);
        chk("mis_inst", inst, NOP);
        chk("mis_inst_err", 32'(inst_err), 32'd1);
        chk("mis_inst_pc", inst_pc, 32'h8000_0102);
        chk("mis_no_req", 32'(imem_req_valid), 32'd0);
        cyc(1, 1, 0, '0);

        // Reset in the middle of WAIT, then a late response.
        lat = 3;
        cyc(1, 0, 0, '0);
        cyc(0, 0, 0, '0);
        inject = 1'b1;
        do_reset();
        #1;
        chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("post_rst_req_addr", imem_req_addr, 32'h8000_0000);
        chk("post_rst_no_inst", 32'(inst_valid), 32'd0);
        cyc(0, 0, 0, '0);
        #1;
        chk("late_rsp_req_addr", imem_req_addr, 32'h8000_0000);
        chk("late_rsp_no_inst", 32'(inst_valid), 32'd0);
        inject = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            lat = int'($urandom_range(1, 3));
            rpc = 32'h8000_0000 + (32'($urandom_range(0, 255)) << 2);
            if ($urandom_range(0, 4) == 0) rpc = rpc + 32'($urandom_range(1, 3));
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                $urandom_range(0, 19) == 0, rpc);
        end

        // Fetch keeps making progress once everything is ready.
        h0    = n_hs;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            lat = 1;
            cyc(1, 1, 0, '0);
            if (n_hs - h0 >= 3) found = 1'b1;
        end
        chk("drain_progress", 32'(found), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h8000_0000, address of the first fetch after reset.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 imem_req_ready  input  1  memory accepts the request.
REQ-006 imem_req_addr  output  32  fetch address, word-aligned.
REQ-007 imem_rsp_valid  input  1  response beat present; no backpressure on the response.
REQ-008 imem_rsp_data  input  32  fetched instruction word.
REQ-009 imem_rsp_err  input  1  access fault for this response.
REQ-010 inst_valid  output  1  instruction offered to the decode stage.
REQ-011 inst_ready  input  1  decode stage accepts the instruction.
REQ-012 inst  output  32  instruction word for decode.
REQ-013 inst_pc  output  32  PC of inst.
REQ-014 inst_err  output  1  inst carries an access or misalignment fault.
REQ-015 redirect_valid  input  1  one-cycle PC redirect from execute (jump/branch).
REQ-016 redirect_pc  input  32  redirect target.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT, OUT; IDLE -> REQ unconditionally on the first cycle after reset release.
REQ-018 In REQ, imem_req_valid=1 and imem_req_addr=pc; on imem_req_ready=1 -> WAIT.
REQ-019 Once asserted, imem_req_valid and imem_req_addr SHALL hold stable until imem_req_ready=1.
REQ-020 In WAIT, on imem_rsp_valid=1: inst/inst_err register rsp_data/rsp_err, inst_pc=pc, -> OUT; a response never arrives in the same cycle as acceptance (minimum latency 1).
REQ-021 In OUT, inst_valid=1 and inst, inst_pc, inst_err SHALL hold stable until inst_valid&&inst_ready; on handshake pc<=pc+4 (mod 2^32) -> REQ.
REQ-022 Best case throughput: one instruction per 3 cycles (REQ, WAIT, OUT), no combinational path from any input to imem_req_valid or inst_valid.
REQ-023 redirect_valid in IDLE or OUT: pc<=redirect_pc, buffered instruction discarded (inst_valid low next cycle), -> REQ; takes precedence over a same-cycle inst handshake, which still counts as consumed.
REQ-024 redirect_valid in REQ before acceptance: request completes at the old address, redirect_pc latched, kill flag set; response is dropped in WAIT, then pc<=latched target -> REQ.
REQ-025 redirect_valid in WAIT: target latched, kill flag set; the pending response is dropped on arrival -> REQ at the target.
REQ-026 A later redirect while kill is set SHALL overwrite the latched target (last wins); exactly one response is dropped per outstanding request.
REQ-027 redirect_pc[1:0]!=0: no memory request; FSM goes directly to OUT with inst=32'h0000_0013 (nop), inst_pc=redirect_pc, inst_err=1.
REQ-028 inst_err=1 SHALL be presented like any instruction; recovery is only by redirect.

Reset
REQ-029 rst_n=0 SHALL immediately force: state=IDLE, pc=RESET_PC, kill=0, imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, inst_err=0.
REQ-030 Reset during WAIT SHALL abandon the outstanding request; a response arriving after reset release while in IDLE/REQ is ignored.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, RESET_PC default, the NOP encoding 32'h0000_0013 and PC increment constant 4.
REQ-032 One sub-module, ifu_pc_reg, SHALL hold pc, latched redirect target and kill flag; FSM and output register stay in ifu_fetch.

Verification
REQ-033 Reset release, memory ready always, 1-cycle response of 32'h0010_0093 -> req addr 32'h8000_0000, inst_valid with inst=32'h0010_0093, inst_pc=32'h8000_0000, next req 32'h8000_0004.
REQ-034 Hold inst_ready=0 for 5 cycles in OUT -> inst/inst_pc unchanged, no new request issued.
REQ-035 Redirect to 32'h8000_0100 during WAIT -> that response never seen at inst_valid; next req addr 32'h8000_0100.
REQ-036 imem_req_ready=0 for 4 cycles with redirect in cycle 2 -> addr stays 32'h8000_0000 until accepted, response dropped, then req 32'h8000_0104 if target 32'h8000_0104.
REQ-037 Redirect to 32'h8000_0102 -> no request; inst_valid with inst=32'h0000_0013, inst_err=1, inst_pc=32'h8000_0102.
REQ-038 rst_n low mid-WAIT for 1 cycle, then late rsp_valid -> outputs at reset values, first request re-issued at 32'h8000_0000.
